mdu_ctrl: RTL

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 76 +++++++
 1 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide unit controller with HI/LO registers
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAXC + 1);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   logic [1:0] op;
   logic [31:0] op_a, op_b, ua, ub, uq, ur, quo, rem;
   logic [63:0] ext_a, ext_b, prod;
   logic sgn;
   assign busy = state == RUN;
   assign stall = busy | (start & ~md_op[2]);
   // results from the latched operands; signed ops go through magnitudes
   always_comb begin
      sgn = ~op[0];
      ext_a = {{32{sgn & op_a[31]}}, op_a};
      ext_b = {{32{sgn & op_b[31]}}, op_b};
      prod = ext_a * ext_b;
      ua = (sgn & op_a[31]) ? -op_a : op_a;
      ub = (sgn & op_b[31]) ? -op_b : op_b;
      uq = ua / ub;
      ur = ua % ub;
      quo = (sgn & (op_a[31] ^ op_b[31])) ? -uq : uq;
      rem = (sgn & op_a[31]) ? -ur : ur;
   end
   // issue in IDLE, count down in RUN, write HI/LO as busy falls
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         op <= '0;
         op_a <= '0;
         op_b <= '0;
         hi <= '0;
         lo <= '0;
      end else if (state == IDLE) begin
         if (start & ~md_op[2]) begin
            op_a <= a;
            op_b <= b;
            op <= md_op[1:0];
            cnt <= md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            state <= RUN;
         end else if (start & (md_op == 3'd4)) begin
            hi <= a;
         end else if (start & (md_op == 3'd5)) begin
            lo <= a;
         end
      end else if (cnt == CW'(1)) begin
         state <= IDLE;
         cnt <= '0;
         if (~op[1]) begin
            {hi, lo} <= prod;
         end else if (op_b != '0) begin
            hi <= rem;
            lo <= quo;
         end
      end else begin
         cnt <= cnt - CW'(1);
      end
   end
endmodule
